// File: rtl/ervp_rr_arbiter.sv
// Round-robin arbiter: a registered grant is held until the owner pulses done,
// or until an optional hold timeout force-releases it.
module ervp_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BW_INDEX = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic                clk,
    input  logic                rstp,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                done,
    output logic                grant_valid,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic [BW_INDEX-1:0] grant_index,
    output logic                timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [BW_INDEX-1:0] LAST_INDEX = BW_INDEX'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                state_q, state_d;
    logic [BW_INDEX-1:0]   ptr_q, ptr_d;
    logic [BW_INDEX-1:0]   index_q, index_d;
    logic [NUM_REQ-1:0]    onehot_q, onehot_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  timeout_q, timeout_d;

    logic [2*NUM_REQ-1:0]  req_rot;
    logic                  scan_found;
    logic [BW_INDEX-1:0]   scan_index;
    logic [BW_INDEX-1:0]   ptr_after;
    logic                  hold_expired;

    // Rotating the doubled request vector puts the pointer position at bit 0,
    // so the first set bit gives the wrap-around distance from ptr.
    always_comb begin
        req_rot    = {req, req} >> ptr_q;
        scan_found = 1'b0;
        scan_index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!scan_found && req_rot[k]) begin
                scan_found = 1'b1;
                if (int'(ptr_q) + k >= NUM_REQ) begin
                    scan_index = BW_INDEX'(int'(ptr_q) + k - NUM_REQ);
                end else begin
                    scan_index = BW_INDEX'(int'(ptr_q) + k);
                end
            end
        end
    end

    assign ptr_after    = (index_q == LAST_INDEX) ? '0 : index_q + 1'b1;
    assign hold_expired = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        index_d   = index_q;
        onehot_d  = onehot_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    state_d  = BUSY;
                    index_d  = scan_index;
                    onehot_d = NUM_REQ'(1) << scan_index;
                    hold_d   = '0;
                end
            end
            BUSY: begin
                // done takes precedence, so a timeout is only flagged when done is absent
                if (done || hold_expired) begin
                    state_d   = IDLE;
                    ptr_d     = ptr_after;
                    index_d   = '0;
                    onehot_d  = '0;
                    hold_d    = '0;
                    timeout_d = !done;
                end else if (MAX_HOLD > 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            index_q   <= '0;
            onehot_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            index_q   <= index_d;
            onehot_q  <= onehot_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid  = (state_q == BUSY);
    assign grant_onehot = onehot_q;
    assign grant_index  = index_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ervp_rr_arbiter.sv
// Directed bench for ervp_rr_arbiter: a 4-requester instance, a 4-requester
// instance with MAX_HOLD=5 and a 3-requester instance share one clock and reset.
module tb_ervp_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstp;

    logic [3:0] req_a;
    logic       done_a;
    logic       gv_a;
    logic [3:0] go_a;
    logic [1:0] gi_a;
    logic       to_a;

    logic [3:0] req_t;
    logic       done_t;
    logic       gv_t;
    logic [3:0] go_t;
    logic [1:0] gi_t;
    logic       to_t;

    logic [2:0] req_c;
    logic       done_c;
    logic       gv_c;
    logic [2:0] go_c;
    logic [1:0] gi_c;
    logic       to_c;

    logic [7:0] obs_a;
    logic [7:0] obs_t;
    logic [6:0] obs_c;
    assign obs_a = {gv_a, go_a, gi_a, to_a};
    assign obs_t = {gv_t, go_t, gi_t, to_t};
    assign obs_c = {gv_c, go_c, gi_c, to_c};

    int checks = 0;
    int passes = 0;

    ervp_rr_arbiter #(.NUM_REQ(4), .BW_INDEX(2), .MAX_HOLD(0)) dut_a (
        .clk(clk), .rstp(rstp), .req(req_a), .done(done_a),
        .grant_valid(gv_a), .grant_onehot(go_a), .grant_index(gi_a), .timeout(to_a)
    );

    ervp_rr_arbiter #(.NUM_REQ(4), .BW_INDEX(2), .MAX_HOLD(5)) dut_t (
        .clk(clk), .rstp(rstp), .req(req_t), .done(done_t),
        .grant_valid(gv_t), .grant_onehot(go_t), .grant_index(gi_t), .timeout(to_t)
    );

    ervp_rr_arbiter #(.NUM_REQ(3), .BW_INDEX(2), .MAX_HOLD(0)) dut_c (
        .clk(clk), .rstp(rstp), .req(req_c), .done(done_c),
        .grant_valid(gv_c), .grant_onehot(go_c), .grant_index(gi_c), .timeout(to_c)
    );

    // Expected {valid, onehot, index, timeout} for a 4-requester instance
    function automatic logic [7:0] exp4(input logic valid, input int idx, input logic tmo);
        logic [1:0] i2;
        logic [3:0] oh;
        i2 = idx[1:0];
        oh = 4'b0000;
        if (valid) oh[i2] = 1'b1;
        return {valid, oh, (valid ? i2 : 2'b00), tmo};
    endfunction

    function automatic logic [6:0] exp3(input logic valid, input int idx);
        logic [1:0] i2;
        logic [2:0] oh;
        i2 = idx[1:0];
        oh = 3'b000;
        if (valid) oh[i2] = 1'b1;
        return {valid, oh, (valid ? i2 : 2'b00), 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstp = 1'b1;
        req_a = 4'b0; done_a = 1'b0;
        req_t = 4'b0; done_t = 1'b0;
        req_c = 3'b0; done_c = 1'b0;
        tick();
        tick();
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL reset_a: got %b want %b", obs_a, 8'h00);
        else passes++;
        checks++;
        if (obs_t !== 8'h00) $display("[TB] FAIL reset_t: got %b want %b", obs_t, 8'h00);
        else passes++;
        checks++;
        if (obs_c !== 7'h00) $display("[TB] FAIL reset_c: got %b want %b", obs_c, 7'h00);
        else passes++;
        rstp = 1'b0;
        tick();
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL idle_no_req: got %b want %b", obs_a, 8'h00);
        else passes++;
    endtask

    // All four requesting: grants 0,1,2,3,0 with one idle cycle after each done
    task automatic test_round_robin();
        req_a = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_a !== exp4(1'b1, k % 4, 1'b0))
                $display("[TB] FAIL rr_grant%0d: got %b want %b", k, obs_a, exp4(1'b1, k % 4, 1'b0));
            else passes++;
            done_a = 1'b1;
            tick();
            done_a = 1'b0;
            checks++;
            if (obs_a !== 8'h00) $display("[TB] FAIL rr_idle%0d: got %b want %b", k, obs_a, 8'h00);
            else passes++;
            if (k == 4) req_a = 4'b0000;
            tick();
        end
    endtask

    // ptr=1: owner 1 drops req, grant must hold until done arrives
    task automatic test_hold_stable();
        req_a = 4'b0010;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 1, 1'b0)) $display("[TB] FAIL hold_grant: got %b want %b", obs_a, exp4(1'b1, 1, 1'b0));
        else passes++;
        req_a = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs_a !== exp4(1'b1, 1, 1'b0))
                $display("[TB] FAIL hold_cycle%0d: got %b want %b", c, obs_a, exp4(1'b1, 1, 1'b0));
            else passes++;
        end
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL hold_release: got %b want %b", obs_a, 8'h00);
        else passes++;
    endtask

    // ptr=2: grant 2 moves ptr to 3, then req=0010 must wrap to index 1 and leave ptr=2
    task automatic test_wrap_scan();
        req_a = 4'b0100;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 2, 1'b0)) $display("[TB] FAIL wrap_setup: got %b want %b", obs_a, exp4(1'b1, 2, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
        req_a = 4'b0010;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 1, 1'b0)) $display("[TB] FAIL wrap_grant: got %b want %b", obs_a, exp4(1'b1, 1, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
        req_a = 4'b1111;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 2, 1'b0)) $display("[TB] FAIL wrap_ptr_after: got %b want %b", obs_a, exp4(1'b1, 2, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
    endtask

    // ptr=3: done while idle must not disturb state or ptr
    task automatic test_done_in_idle();
        done_a = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL idle_done_outputs: got %b want %b", obs_a, 8'h00);
        else passes++;
        done_a = 1'b0;
        req_a = 4'b1111;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 3, 1'b0)) $display("[TB] FAIL idle_done_ptr: got %b want %b", obs_a, exp4(1'b1, 3, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
    endtask

    // ptr=0 on entry; reset while busy drops the grant and restarts ptr at 0
    task automatic test_reset_busy();
        req_a = 4'b0010;
        tick();
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
        req_a = 4'b1000;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 3, 1'b0)) $display("[TB] FAIL rstbusy_grant: got %b want %b", obs_a, exp4(1'b1, 3, 1'b0));
        else passes++;
        rstp = 1'b1;
        tick();
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL rstbusy_drop: got %b want %b", obs_a, 8'h00);
        else passes++;
        rstp = 1'b0;
        req_a = 4'b1001;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 0, 1'b0)) $display("[TB] FAIL rstbusy_ptr0: got %b want %b", obs_a, exp4(1'b1, 0, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
        req_a = 4'b1000;
        tick();
        rstp = 1'b1;
        tick();
        checks++;
        if (obs_a !== 8'h00) $display("[TB] FAIL rstbusy_drop2: got %b want %b", obs_a, 8'h00);
        else passes++;
        rstp = 1'b0;
        tick();
        checks++;
        if (obs_a !== exp4(1'b1, 3, 1'b0)) $display("[TB] FAIL rstbusy_regrant: got %b want %b", obs_a, exp4(1'b1, 3, 1'b0));
        else passes++;
        req_a = 4'b0000; done_a = 1'b1;
        tick();
        done_a = 1'b0;
    endtask

    // MAX_HOLD=5: grant visible for 5 cycles, then timeout pulse with the release
    task automatic test_timeout();
        req_t = 4'b0001;
        tick();
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obs_t !== exp4(1'b1, 0, 1'b0))
                $display("[TB] FAIL to_hold%0d: got %b want %b", c, obs_t, exp4(1'b1, 0, 1'b0));
            else passes++;
            if (c < 5) tick();
        end
        tick();
        checks++;
        if (obs_t !== exp4(1'b0, 0, 1'b1)) $display("[TB] FAIL to_pulse: got %b want %b", obs_t, exp4(1'b0, 0, 1'b1));
        else passes++;
        req_t = 4'b0011;
        tick();
        checks++;
        if (obs_t !== exp4(1'b1, 1, 1'b0)) $display("[TB] FAIL to_ptr_advance: got %b want %b", obs_t, exp4(1'b1, 1, 1'b0));
        else passes++;
        for (int c = 2; c <= 5; c++) tick();
        checks++;
        if (obs_t !== exp4(1'b1, 1, 1'b0)) $display("[TB] FAIL to_counter_clear: got %b want %b", obs_t, exp4(1'b1, 1, 1'b0));
        else passes++;
        done_t = 1'b1;
        req_t = 4'b0000;
        tick();
        done_t = 1'b0;
        checks++;
        if (obs_t !== 8'h00) $display("[TB] FAIL to_done_wins: got %b want %b", obs_t, 8'h00);
        else passes++;
        tick();
        checks++;
        if (obs_t !== 8'h00) $display("[TB] FAIL to_quiet: got %b want %b", obs_t, 8'h00);
        else passes++;
    endtask

    // NUM_REQ=3: grants 0,1,2,0, never index 3
    task automatic test_three_req();
        req_c = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_c !== exp3(1'b1, k % 3))
                $display("[TB] FAIL three_grant%0d: got %b want %b", k, obs_c, exp3(1'b1, k % 3));
            else passes++;
            done_c = 1'b1;
            tick();
            done_c = 1'b0;
            checks++;
            if (obs_c !== 7'h00) $display("[TB] FAIL three_idle%0d: got %b want %b", k, obs_c, 7'h00);
            else passes++;
            if (k == 3) req_c = 3'b000;
            tick();
        end
    endtask

    initial begin
        $display("[TB] starting ervp_rr_arbiter bench");
        test_reset();
        test_round_robin();
        test_hold_stable();
        test_wrap_scan();
        test_done_in_idle();
        test_reset_busy();
        test_timeout();
        test_three_req();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
